// File: rtl/ctrl_unit_mc.sv
// ctrl_unit_mc: RV32IM decode/control stage for the pipelined core.
// Decodes the ID instruction, drives ID branch controls combinationally,
// registers the EX control bundle and sequences multi-cycle MUL/DIV ops.
// Optional feature macro: CTRL_MEXT_EN enables the M-extension sequencer.
module ctrl_unit_mc #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [31:0] inst,
    input  logic       inst_valid,
    input  logic       cmp_res,
    input  logic       stall_in,
    input  logic       flush_in,
    output logic       id_branch,
    output logic       id_jalr,
    output logic       id_rs1use,
    output logic       id_rs2use,
    output logic [2:0] id_cmp_ctrl,
    output logic       id_stall,
    output logic       md_start,
    output logic       md_abort,
    output logic [2:0] md_op,
    output logic       ex_valid,
    output logic       ex_alusrc_a,
    output logic       ex_alusrc_b,
    output logic       ex_datatoreg,
    output logic       ex_regwrite,
    output logic       ex_mem_w,
    output logic       ex_mio,
    output logic       ex_md_sel,
    output logic       ex_illegal,
    output logic [3:0] ex_alu_ctrl,
    output logic [2:0] ex_imm_sel,
    output logic [1:0] ex_hazard_optype,
    output logic [2:0] ex_md_op
);

`ifdef CTRL_MEXT_EN
    localparam logic MextEn = 1'b1;
`else
    localparam logic MextEn = 1'b0;
`endif

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [CNT_W-1:0] MulCnt = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DivCnt = CNT_W'(DIV_LAT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic       valid;
        logic       alusrcA;
        logic       alusrcB;
        logic       datatoreg;
        logic       regwrite;
        logic       memW;
        logic       mio;
        logic       mdSel;
        logic       illegal;
        logic [3:0] aluCtrl;
        logic [2:0] immSel;
        logic [1:0] hazOp;
        logic [2:0] mdOp;
    } exBundle_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unusedInstBits;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign unusedInstBits = ^{inst[24:15], inst[11:7]};

    exBundle_t  dec;
    exBundle_t  exBundle_d, exBundle_q;
    logic       isMop, isBranch, isJump, isJalr, rs1Use, rs2Use, legal;
    logic [2:0] cmpCtrl;
    state_t     state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [2:0] opReg_d, opReg_q;
    logic       mdStart, mdAbort, busyStall;

    // Register/immediate ALU op from funct3; alt selects SUB or SRA.
    function automatic logic [3:0] aluCode(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  aluCode = alt ? 4'd2 : 4'd1;
            3'b001:  aluCode = 4'd3;
            3'b010:  aluCode = 4'd4;
            3'b011:  aluCode = 4'd5;
            3'b100:  aluCode = 4'd6;
            3'b101:  aluCode = alt ? 4'd10 : 4'd7;
            3'b110:  aluCode = 4'd8;
            default: aluCode = 4'd9;
        endcase
    endfunction

    // Instruction decode into the EX bundle and the ID-resolved controls.
    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        legal     = 1'b1;
        isMop     = 1'b0;
        isBranch  = 1'b0;
        isJump    = 1'b0;
        isJalr    = 1'b0;
        rs1Use    = 1'b0;
        rs2Use    = 1'b0;
        cmpCtrl   = 3'd0;
        case (opcode)
            OpR: begin
                rs1Use = 1'b1;
                rs2Use = 1'b1;
                dec.regwrite = 1'b1;
                dec.hazOp    = 2'd1;
                if (funct7 == 7'h01 && MextEn) begin
                    isMop     = 1'b1;
                    dec.mdSel = 1'b1;
                    dec.mdOp  = funct3;
                end else if (funct7 == 7'h00 ||
                             (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    dec.aluCtrl = aluCode(funct3, funct7[5]);
                end else begin
                    legal = 1'b0;
                end
            end
            OpImm: begin
                rs1Use = 1'b1;
                dec.alusrcB  = 1'b1;
                dec.regwrite = 1'b1;
                dec.hazOp    = 2'd1;
                dec.immSel   = 3'd1;
                dec.aluCtrl  = aluCode(funct3, funct7[5] && funct3 == 3'b101);
                if ((funct3 == 3'b001 && funct7 != 7'h00) ||
                    (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20))
                    legal = 1'b0;
            end
            OpLoad: begin
                rs1Use = 1'b1;
                dec.alusrcB   = 1'b1;
                dec.datatoreg = 1'b1;
                dec.regwrite  = 1'b1;
                dec.mio       = 1'b1;
                dec.hazOp     = 2'd2;
                dec.immSel    = 3'd1;
                dec.aluCtrl   = 4'd1;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
                    legal = 1'b0;
            end
            OpStore: begin
                rs1Use = 1'b1;
                rs2Use = 1'b1;
                dec.alusrcB = 1'b1;
                dec.memW    = 1'b1;
                dec.mio     = 1'b1;
                dec.hazOp   = 2'd3;
                dec.immSel  = 3'd4;
                dec.aluCtrl = 4'd1;
                if (funct3[2] || funct3 == 3'b011)
                    legal = 1'b0;
            end
            OpBranch: begin
                rs1Use     = 1'b1;
                rs2Use     = 1'b1;
                isBranch   = 1'b1;
                dec.immSel = 3'd2;
                case (funct3)
                    3'b000:  cmpCtrl = 3'd1;
                    3'b001:  cmpCtrl = 3'd2;
                    3'b100:  cmpCtrl = 3'd3;
                    3'b110:  cmpCtrl = 3'd4;
                    3'b101:  cmpCtrl = 3'd5;
                    3'b111:  cmpCtrl = 3'd6;
                    default: legal   = 1'b0;
                endcase
            end
            OpJal: begin
                isJump = 1'b1;
                dec.alusrcA  = 1'b1;
                dec.regwrite = 1'b1;
                dec.hazOp    = 2'd1;
                dec.immSel   = 3'd3;
                dec.aluCtrl  = 4'd11;
            end
            OpJalr: begin
                isJump = 1'b1;
                isJalr = 1'b1;
                rs1Use = 1'b1;
                dec.alusrcA  = 1'b1;
                dec.regwrite = 1'b1;
                dec.hazOp    = 2'd1;
                dec.immSel   = 3'd1;
                dec.aluCtrl  = 4'd11;
                if (funct3 != 3'b000)
                    legal = 1'b0;
            end
            OpLui: begin
                dec.alusrcB  = 1'b1;
                dec.regwrite = 1'b1;
                dec.hazOp    = 2'd1;
                dec.immSel   = 3'd5;
                dec.aluCtrl  = 4'd12;
            end
            OpAuipc: begin
                dec.alusrcA  = 1'b1;
                dec.alusrcB  = 1'b1;
                dec.regwrite = 1'b1;
                dec.hazOp    = 2'd1;
                dec.immSel   = 3'd5;
                dec.aluCtrl  = 4'd1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
            isMop       = 1'b0;
            isBranch    = 1'b0;
            isJump      = 1'b0;
            isJalr      = 1'b0;
            rs1Use      = 1'b0;
            rs2Use      = 1'b0;
            cmpCtrl     = 3'd0;
        end
    end

    assign id_branch   = inst_valid & ((isBranch & cmp_res) | isJump);
    assign id_jalr     = inst_valid & isJalr;
    assign id_rs1use   = inst_valid & rs1Use;
    assign id_rs2use   = inst_valid & rs2Use;
    assign id_cmp_ctrl = inst_valid ? cmpCtrl : 3'd0;

    // MUL/DIV sequencer: launch, count down latency, hold for stall, abort on flush.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opReg_d   = opReg_q;
        mdStart   = 1'b0;
        mdAbort   = 1'b0;
        busyStall = 1'b0;
        md_op     = 3'd0;
        case (state_q)
            IDLE: begin
                if (inst_valid && isMop && !flush_in) begin
                    mdStart   = 1'b1;
                    busyStall = 1'b1;
                    md_op     = funct3;
                    opReg_d   = funct3;
                    cnt_d     = funct3[2] ? DivCnt : MulCnt;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                md_op     = opReg_q;
                busyStall = (cnt_q != '0) | stall_in;
                if (flush_in) begin
                    mdAbort = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!stall_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign md_start = mdStart & rst_n;
    assign md_abort = mdAbort;
    assign id_stall = stall_in | busyStall;

    // Sequencer state, latency counter and in-flight funct3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opReg_q <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opReg_q <= opReg_d;
        end
    end

    assign exBundle_d = (flush_in || id_stall || !inst_valid) ? '0 : dec;

    // EX control bundle pipeline register; bubbles on flush, stall or empty slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exBundle_q <= '0;
        end else begin
            exBundle_q <= exBundle_d;
        end
    end

    assign ex_valid         = exBundle_q.valid;
    assign ex_alusrc_a      = exBundle_q.alusrcA;
    assign ex_alusrc_b      = exBundle_q.alusrcB;
    assign ex_datatoreg     = exBundle_q.datatoreg;
    assign ex_regwrite      = exBundle_q.regwrite;
    assign ex_mem_w         = exBundle_q.memW;
    assign ex_mio           = exBundle_q.mio;
    assign ex_md_sel        = exBundle_q.mdSel;
    assign ex_illegal       = exBundle_q.illegal;
    assign ex_alu_ctrl      = exBundle_q.aluCtrl;
    assign ex_imm_sel       = exBundle_q.immSel;
    assign ex_hazard_optype = exBundle_q.hazOp;
    assign ex_md_op         = exBundle_q.mdOp;

endmodule

// File: tb/tb_ctrl_unit_mc.sv
// tb_ctrl_unit_mc: directed self-checking bench for ctrl_unit_mc.
// M-extension sequencing steps are compiled in when CTRL_MEXT_EN is defined.
module tb_ctrl_unit_mc;

    localparam logic [31:0] InstAdd  = 32'h002081B3;
    localparam logic [31:0] InstAddi = 32'h00108093;
    localparam logic [31:0] InstLw   = 32'h00402183;
    localparam logic [31:0] InstSw   = 32'h0020A423;
    localparam logic [31:0] InstLui  = 32'h123452B7;
    localparam logic [31:0] InstJal  = 32'h008000EF;
    localparam logic [31:0] InstBeq  = 32'h00208463;
    localparam logic [31:0] InstBltu = 32'h0020E463;
    localparam logic [31:0] InstBgeu = 32'h0020F463;
    localparam logic [31:0] InstBad  = 32'hFFFFFFFF;
    localparam logic [31:0] InstMul  = 32'h022081B3;
    localparam logic [31:0] InstDiv  = 32'h0220C1B3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst;
    logic        inst_valid, cmp_res, stall_in, flush_in;
    logic        id_branch, id_jalr, id_rs1use, id_rs2use, id_stall;
    logic [2:0]  id_cmp_ctrl, md_op;
    logic        md_start, md_abort;
    logic        ex_valid, ex_alusrc_a, ex_alusrc_b, ex_datatoreg, ex_regwrite;
    logic        ex_mem_w, ex_mio, ex_md_sel, ex_illegal;
    logic [3:0]  ex_alu_ctrl;
    logic [2:0]  ex_imm_sel, ex_md_op;
    logic [1:0]  ex_hazard_optype;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    ctrl_unit_mc dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .inst_valid(inst_valid),
        .cmp_res(cmp_res), .stall_in(stall_in), .flush_in(flush_in),
        .id_branch(id_branch), .id_jalr(id_jalr), .id_rs1use(id_rs1use),
        .id_rs2use(id_rs2use), .id_cmp_ctrl(id_cmp_ctrl), .id_stall(id_stall),
        .md_start(md_start), .md_abort(md_abort), .md_op(md_op),
        .ex_valid(ex_valid), .ex_alusrc_a(ex_alusrc_a), .ex_alusrc_b(ex_alusrc_b),
        .ex_datatoreg(ex_datatoreg), .ex_regwrite(ex_regwrite), .ex_mem_w(ex_mem_w),
        .ex_mio(ex_mio), .ex_md_sel(ex_md_sel), .ex_illegal(ex_illegal),
        .ex_alu_ctrl(ex_alu_ctrl), .ex_imm_sel(ex_imm_sel),
        .ex_hazard_optype(ex_hazard_optype), .ex_md_op(ex_md_op)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] i, input logic v, input logic c,
                                 input logic s, input logic f);
        @(negedge clk);
        inst       = i;
        inst_valid = v;
        cmp_res    = c;
        stall_in   = s;
        flush_in   = f;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; inst = 32'h0; inst_valid = 1'b0;
        cmp_res = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ex_valid", ex_valid, 0);
        checkOutput("rst_ex_regwrite", ex_regwrite, 0);
        checkOutput("rst_md_start", md_start, 0);
        checkOutput("rst_md_abort", md_abort, 0);
        @(negedge clk) rst_n = 1'b1;

        applyStimulus(InstAdd, 1, 0, 0, 0);
        checkOutput("add_id_stall", id_stall, 0);
        checkOutput("add_rs2use", id_rs2use, 1);
        stepClock();
        checkOutput("add_ex_valid", ex_valid, 1);
        checkOutput("add_ex_alu", ex_alu_ctrl, 1);
        checkOutput("add_ex_regwrite", ex_regwrite, 1);
        checkOutput("add_ex_optype", ex_hazard_optype, 1);
        checkOutput("add_ex_illegal", ex_illegal, 0);

        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_ex_valid", ex_valid, 0);
        checkOutput("midrst_ex_alu", ex_alu_ctrl, 0);
        checkOutput("midrst_ex_regwrite", ex_regwrite, 0);
        @(negedge clk) rst_n = 1'b1;

        applyStimulus(InstAddi, 1, 0, 0, 0);
        stepClock();
        checkOutput("addi_ex_alusrc_b", ex_alusrc_b, 1);
        checkOutput("addi_ex_imm_sel", ex_imm_sel, 1);

        applyStimulus(InstLw, 1, 0, 0, 0);
        stepClock();
        checkOutput("lw_ex_datatoreg", ex_datatoreg, 1);
        checkOutput("lw_ex_mio", ex_mio, 1);
        checkOutput("lw_ex_optype", ex_hazard_optype, 2);

        applyStimulus(InstSw, 1, 0, 0, 0);
        stepClock();
        checkOutput("sw_ex_mem_w", ex_mem_w, 1);
        checkOutput("sw_ex_regwrite", ex_regwrite, 0);
        checkOutput("sw_ex_imm_sel", ex_imm_sel, 4);
        checkOutput("sw_ex_optype", ex_hazard_optype, 3);

        applyStimulus(InstLui, 1, 0, 0, 0);
        stepClock();
        checkOutput("lui_ex_alu", ex_alu_ctrl, 12);
        checkOutput("lui_ex_imm_sel", ex_imm_sel, 5);

        applyStimulus(InstJal, 1, 0, 0, 0);
        checkOutput("jal_id_branch", id_branch, 1);
        checkOutput("jal_id_jalr", id_jalr, 0);
        stepClock();
        checkOutput("jal_ex_alu", ex_alu_ctrl, 11);
        checkOutput("jal_ex_alusrc_a", ex_alusrc_a, 1);
        checkOutput("jal_ex_imm_sel", ex_imm_sel, 3);

        applyStimulus(InstBeq, 1, 1, 0, 0);
        checkOutput("beq_taken_branch", id_branch, 1);
        checkOutput("beq_cmp_ctrl", id_cmp_ctrl, 1);
        stepClock();
        checkOutput("beq_ex_regwrite", ex_regwrite, 0);
        checkOutput("beq_ex_imm_sel", ex_imm_sel, 2);
        applyStimulus(InstBeq, 1, 0, 0, 0);
        checkOutput("beq_nottaken_branch", id_branch, 0);
        applyStimulus(InstBeq, 0, 1, 0, 0);
        checkOutput("beq_invalid_branch", id_branch, 0);
        stepClock();
        checkOutput("beq_invalid_ex_valid", ex_valid, 0);
        applyStimulus(InstBltu, 1, 0, 0, 0);
        checkOutput("bltu_cmp_ctrl", id_cmp_ctrl, 4);
        applyStimulus(InstBgeu, 1, 0, 0, 0);
        checkOutput("bgeu_cmp_ctrl", id_cmp_ctrl, 6);

        applyStimulus(InstBad, 1, 0, 0, 0);
        stepClock();
        checkOutput("bad_ex_illegal", ex_illegal, 1);
        checkOutput("bad_ex_regwrite", ex_regwrite, 0);
        checkOutput("bad_ex_mem_w", ex_mem_w, 0);

        applyStimulus(InstAdd, 1, 0, 1, 0);
        checkOutput("stallin_id_stall", id_stall, 1);
        stepClock();
        checkOutput("stallin_ex_valid", ex_valid, 0);
        applyStimulus(InstAdd, 1, 0, 1, 1);
        stepClock();
        checkOutput("flush_ex_valid", ex_valid, 0);

`ifndef CTRL_MEXT_EN
        applyStimulus(InstMul, 1, 0, 0, 0);
        checkOutput("nomext_id_stall", id_stall, 0);
        checkOutput("nomext_md_start", md_start, 0);
        stepClock();
        checkOutput("nomext_ex_illegal", ex_illegal, 1);
        checkOutput("nomext_ex_regwrite", ex_regwrite, 0);
        checkOutput("nomext_ex_md_sel", ex_md_sel, 0);
`else
        // MUL with the default two-cycle latency
        applyStimulus(InstMul, 1, 0, 0, 0);
        checkOutput("mul_t0_md_start", md_start, 1);
        checkOutput("mul_t0_id_stall", id_stall, 1);
        checkOutput("mul_t0_md_op", md_op, 0);
        stepClock();
        checkOutput("mul_t0_ex_valid", ex_valid, 0);
        applyStimulus(InstMul, 1, 0, 0, 0);
        checkOutput("mul_t1_md_start", md_start, 0);
        checkOutput("mul_t1_id_stall", id_stall, 1);
        stepClock();
        checkOutput("mul_t1_ex_valid", ex_valid, 0);
        applyStimulus(InstMul, 1, 0, 0, 0);
        checkOutput("mul_t2_id_stall", id_stall, 0);
        stepClock();
        checkOutput("mul_ex_md_sel", ex_md_sel, 1);
        checkOutput("mul_ex_regwrite", ex_regwrite, 1);
        checkOutput("mul_ex_md_op", ex_md_op, 0);
        applyStimulus(InstAdd, 1, 0, 0, 0);
        checkOutput("mul_after_id_stall", id_stall, 0);
        stepClock();

        // DIV aborted by a flush on its tenth busy cycle
        applyStimulus(InstDiv, 1, 0, 0, 0);
        checkOutput("div_md_start", md_start, 1);
        checkOutput("div_md_op", md_op, 4);
        stepClock();
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(InstDiv, 1, 0, 0, 0);
            checkOutput("div_busy_stall", id_stall, 1);
            stepClock();
        end
        applyStimulus(InstDiv, 1, 0, 0, 1);
        checkOutput("div_flush_md_abort", md_abort, 1);
        stepClock();
        checkOutput("div_flush_ex_valid", ex_valid, 0);
        applyStimulus(InstAdd, 1, 0, 0, 0);
        checkOutput("div_after_id_stall", id_stall, 0);
        checkOutput("div_after_md_abort", md_abort, 0);
        stepClock();
        checkOutput("div_after_ex_valid", ex_valid, 1);
        checkOutput("div_after_ex_md_sel", ex_md_sel, 0);

        // MUL finishing under three cycles of external stall
        applyStimulus(InstMul, 1, 0, 0, 0);
        stepClock();
        applyStimulus(InstMul, 1, 0, 0, 0);
        stepClock();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(InstMul, 1, 0, 1, 0);
            checkOutput("mulst_id_stall", id_stall, 1);
            checkOutput("mulst_md_start", md_start, 0);
            stepClock();
            checkOutput("mulst_ex_valid", ex_valid, 0);
        end
        applyStimulus(InstMul, 1, 0, 0, 0);
        checkOutput("mulst_release_stall", id_stall, 0);
        stepClock();
        checkOutput("mulst_ex_md_sel", ex_md_sel, 1);
        checkOutput("mulst_ex_valid", ex_valid, 1);
        applyStimulus(InstAdd, 1, 0, 0, 0);
        stepClock();
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
